// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode constants, instruction field positions,
// the registered decode record and the opcode classification function.
package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       is_alu_r;
        logic       is_alu_imm;
    } dec_t;

    // Fields are always extracted; the classes are mutually exclusive by
    // construction, since each opcode lands in at most one case arm.
    function automatic dec_t classify(input logic [31:0] ir);
        dec_t d;
        d            = '0;
        d.opcode     = ir[OPCODE_MSB:OPCODE_LSB];
        d.rs         = ir[RS_MSB:RS_LSB];
        d.rt         = ir[RT_MSB:RT_LSB];
        case (d.opcode)
            OP_RTYPE:                          d.is_alu_r   = (ir != 32'h0);
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  d.is_branch  = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  d.is_alu_imm = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: d.is_load  = 1'b1;
            OP_SB, OP_SH, OP_SW:               d.is_store   = 1'b1;
            default:                           ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ins_analyser_decode.sv
// Instruction pre-decoder: registered opcode/rs/rt fields and one-hot-or-zero class flags.
// Latency: one cycle (IR at edge N decoded during cycle N+1).
// Backpressure: none; a new IR is accepted every cycle.
module ins_analyser_decode
    import cpu_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        isBranch,
    output logic        isLoad,
    output logic        isStore,
    output logic        isALUR,
    output logic        isALUImm
);

    dec_t dec_d;
    dec_t dec_q;

    always_comb begin
        dec_d = classify(IR);
        assert ($onehot0({dec_d.is_branch, dec_d.is_load, dec_d.is_store,
                          dec_d.is_alu_r, dec_d.is_alu_imm}))
            else $error("decode class flags not mutually exclusive");
    end

    // Reset forces a NOP decode regardless of IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign opcode   = dec_q.opcode;
    assign rs       = dec_q.rs;
    assign rt       = dec_q.rt;
    assign isBranch = dec_q.is_branch;
    assign isLoad   = dec_q.is_load;
    assign isStore  = dec_q.is_store;
    assign isALUR   = dec_q.is_alu_r;
    assign isALUImm = dec_q.is_alu_imm;

endmodule

// File: tb/tb_ins_analyser_decode.sv
// Testbench for ins_analyser_decode: directed cases, full opcode sweep and
// random traffic checked against a list-based reference decoder.
module tb_ins_analyser_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IR  = 32'h0;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        isBranch;
    logic        isLoad;
    logic        isStore;
    logic        isALUR;
    logic        isALUImm;

    int checks   = 0;
    int failures = 0;

    ins_analyser_decode dut (
        .clk      (clk),
        .rst      (rst),
        .IR       (IR),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .isBranch (isBranch),
        .isLoad   (isLoad),
        .isStore  (isStore),
        .isALUR   (isALUR),
        .isALUImm (isALUImm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: class membership from explicit opcode lists/ranges.
    // Flag order {branch, load, store, alu_r, alu_imm}.
    function automatic logic [4:0] model_flags(input logic [31:0] ir);
        int op;
        int loads[5]  = '{32, 33, 35, 36, 37};
        int stores[3] = '{40, 41, 43};
        logic [4:0] f;
        op = int'(ir >> 26);
        f  = 5'b0;
        if (op == 0 && ir != 32'h0) f[1] = 1'b1;
        if (op >= 4 && op <= 7)     f[4] = 1'b1;
        if (op >= 8 && op <= 15)    f[0] = 1'b1;
        foreach (loads[i])  if (op == loads[i])  f[3] = 1'b1;
        foreach (stores[i]) if (op == stores[i]) f[2] = 1'b1;
        return f;
    endfunction

    function automatic logic [4:0] dut_flags();
        return {isBranch, isLoad, isStore, isALUR, isALUImm};
    endfunction

    // Apply one IR for one edge, then compare everything against the model.
    task automatic step(input logic [31:0] ir, input logic r, input string tag);
        logic [4:0]  ef;
        logic [31:0] ei;
        IR  = ir;
        rst = r;
        @(posedge clk);
        #1;
        ef = r ? 5'b0 : model_flags(ir);
        ei = r ? 32'h0 : ir;
        chk({tag, ".flags"},  32'(dut_flags()), 32'(ef));
        chk({tag, ".opcode"}, 32'(opcode), 32'(ei / 32'h0400_0000));
        chk({tag, ".rs"},     32'(rs), 32'((ei / 32'h0020_0000) % 32));
        chk({tag, ".rt"},     32'(rt), 32'((ei / 32'h0001_0000) % 32));
        chk({tag, ".onehot"}, 32'($onehot0(dut_flags())), 32'd1);
    endtask

    initial begin
        logic [31:0] ir;
        logic        r;

        // Reset beats the incoming load, then the load decodes with no warm-up.
        step(32'h8C22_0004, 1'b1, "reset");
        chk("reset.all_zero", 32'({opcode, rs, rt, dut_flags()}), 32'd0);
        step(32'h8C22_0004, 1'b0, "release");
        chk("release.isLoad", 32'(isLoad), 32'd1);
        chk("release.opcode", 32'(opcode), 32'h23);

        step(32'h0022_1820, 1'b0, "add");
        chk("add.isALUR", 32'(isALUR), 32'd1);
        step(32'h0000_0000, 1'b0, "nop");
        chk("nop.flags", 32'(dut_flags()), 32'd0);
        step(32'h2022_0005, 1'b0, "addi");
        chk("addi.isALUImm", 32'(isALUImm), 32'd1);
        step(32'hAC22_0008, 1'b0, "sw");
        chk("sw.isStore", 32'(isStore), 32'd1);
        step(32'h1022_FFFF, 1'b0, "beq");
        chk("beq.isBranch", 32'(isBranch), 32'd1);
        step(32'h0800_0010, 1'b0, "j");
        chk("j.opcode", 32'(opcode), 32'h02);
        step(32'h0C00_0010, 1'b0, "jal");
        step(32'hFC00_0000, 1'b0, "undef");
        chk("undef.opcode", 32'(opcode), 32'h3F);
        // R-type with only funct bits set still counts as ALU-R.
        step(32'h0000_0001, 1'b0, "rtype_low");
        step(32'h0000_0001, 1'b0, "hold");

        // Back-to-back sweep of every opcode with random low bits.
        for (int op = 0; op < 64; op++) begin
            ir = {6'(op), 26'($urandom)};
            step(ir, 1'b0, "sweep");
        end

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            ir = $urandom;
            if ($urandom_range(0, 3) == 0) ir[31:26] = 6'($urandom_range(0, 15));
            r = ($urandom_range(0, 19) == 0);
            step(ir, r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
